vlog_cmt_strip: RTL

VLOG_CMT_STRIP -- requirements
Module: vlog_cmt_strip

---
 rtl/vlogpp_pkg.sv | 30 +++
 rtl/vlog_cmt_strip.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vlogpp_pkg.sv
// Shared types and character constants for the Verilog preprocessor front end.
package vlogpp_pkg;

    localparam int unsigned CHAR_W = 8;

    // Lexical context of the comment stripper
    typedef enum logic [2:0] {
        ST_CODE     = 3'd0,
        ST_SLASH    = 3'd1,
        ST_LINE_CMT = 3'd2,
        ST_BLK_CMT  = 3'd3,
        ST_BLK_STAR = 3'd4,
        ST_STRING   = 3'd5,
        ST_STR_ESC  = 3'd6
    } state_t;

    // One character on the stream plus its end-of-file marker
    typedef struct packed {
        logic              last;
        logic [CHAR_W-1:0] data;
    } char_beat_t;

    localparam logic [CHAR_W-1:0] CH_SLASH  = 8'h2F;
    localparam logic [CHAR_W-1:0] CH_STAR   = 8'h2A;
    localparam logic [CHAR_W-1:0] CH_QUOTE  = 8'h22;
    localparam logic [CHAR_W-1:0] CH_BSLASH = 8'h5C;
    localparam logic [CHAR_W-1:0] CH_NL     = 8'h0A;
    localparam logic [CHAR_W-1:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/vlog_cmt_strip.sv
// Streaming comment stripper: removes // and /* */ comments from a Verilog
// character stream, keeps string literals intact and preserves line numbering.
module vlog_cmt_strip
    import vlogpp_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  cmt_count,
    output logic              err_unterm
);

    state_t     state;
    state_t     state_nxt;
    logic       can_load;
    logic       slash_flush;
    logic       acc;
    logic       emit;
    logic       cmt_inc;
    logic       err_set;
    char_beat_t beat;

    // Next-state, emitted character and event decode for the current input
    always_comb begin
        can_load    = !out_valid || out_ready;
        // A held '/' not followed by '/' or '*' is released without consuming input
        slash_flush = (state == ST_SLASH) && in_valid &&
                      (in_data != CH_SLASH) && (in_data != CH_STAR);
        in_ready    = can_load && !slash_flush;
        acc         = in_valid && in_ready;

        state_nxt = state;
        emit      = 1'b0;
        cmt_inc   = 1'b0;
        err_set   = 1'b0;
        beat.last = 1'b0;
        beat.data = in_data;

        if (slash_flush && can_load) begin
            emit      = 1'b1;
            beat.data = CH_SLASH;
            state_nxt = ST_CODE;
        end else if (acc) begin
            unique case (state)
                ST_CODE: begin
                    if (in_data == CH_SLASH) begin
                        // No lookahead past end of file: emit the '/' directly
                        if (in_last) begin
                            emit = 1'b1;
                        end else begin
                            state_nxt = ST_SLASH;
                        end
                    end else begin
                        emit = 1'b1;
                        if (in_data == CH_QUOTE) begin
                            state_nxt = ST_STRING;
                        end
                    end
                end
                ST_SLASH: begin
                    // Only '/' or '*' are accepted here
                    if (in_data == CH_SLASH) begin
                        state_nxt = ST_LINE_CMT;
                        cmt_inc   = in_last;
                    end else begin
                        state_nxt = ST_BLK_CMT;
                        err_set   = in_last;
                    end
                end
                ST_LINE_CMT: begin
                    if (in_data == CH_NL) begin
                        emit      = 1'b1;
                        cmt_inc   = 1'b1;
                        state_nxt = ST_CODE;
                    end else begin
                        cmt_inc = in_last;
                    end
                end
                ST_BLK_CMT: begin
                    if (in_data == CH_NL) begin
                        emit = 1'b1;
                    end else if (in_data == CH_STAR) begin
                        state_nxt = ST_BLK_STAR;
                    end
                    err_set = in_last;
                end
                ST_BLK_STAR: begin
                    if (in_data == CH_SLASH) begin
                        emit      = 1'b1;
                        beat.data = CH_SPACE;
                        cmt_inc   = 1'b1;
                        state_nxt = ST_CODE;
                    end else if (in_data == CH_STAR) begin
                        state_nxt = ST_BLK_STAR;
                    end else if (in_data == CH_NL) begin
                        emit      = 1'b1;
                        state_nxt = ST_BLK_CMT;
                    end else begin
                        state_nxt = ST_BLK_CMT;
                    end
                    // A closing '/' on the final character still terminates the comment
                    err_set = in_last && (in_data != CH_SLASH);
                end
                ST_STRING: begin
                    emit = 1'b1;
                    if (in_data == CH_BSLASH) begin
                        state_nxt = ST_STR_ESC;
                    end else if (in_data == CH_QUOTE) begin
                        state_nxt = ST_CODE;
                    end
                    err_set = in_last && (in_data != CH_QUOTE);
                end
                ST_STR_ESC: begin
                    emit      = 1'b1;
                    state_nxt = ST_STRING;
                    err_set   = in_last;
                end
                default: begin
                    state_nxt = ST_CODE;
                end
            endcase

            // End of file always produces a marked character and resets context
            if (in_last) begin
                state_nxt = ST_CODE;
                beat.last = 1'b1;
                if (!emit) begin
                    emit      = 1'b1;
                    beat.data = CH_SPACE;
                end
            end
        end
    end

    // State, output register, comment counter and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CODE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            cmt_count  <= '0;
            err_unterm <= 1'b0;
        end else begin
            state      <= state_nxt;
            err_unterm <= err_set;
            if (cmt_inc && (cmt_count != {CNT_W{1'b1}})) begin
                cmt_count <= cmt_count + CNT_W'(1);
            end
            if (can_load) begin
                out_valid <= emit;
                if (emit) begin
                    out_data <= beat.data;
                    out_last <= beat.last;
                end
            end
        end
    end

endmodule
